// File: rtl/bit_serializer.sv
`timescale 1ns/1ps
// bit_serializer: parallel-to-serial front end for the serial mod-5 detector.
// Takes WIDTH-bit words on a valid/ready handshake and emits them MSB-first,
// one bit per clock. A single pending buffer allows gapless back-to-back words.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   i_in_data    parallel word, sampled only on accept
//   i_in_valid   source presents a word
//   o_in_ready   a word can be taken (accept = i_in_valid && o_in_ready)
//   o_ser_out    serial bit, MSB first, 0 when not valid
//   o_ser_valid  o_ser_out carries a word bit this cycle
//   o_ser_first  current bit is the MSB of a word
//   o_ser_last   current bit is the LSB of a word
//   o_busy       a word is shifting or pending
module bit_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_ser_out,
  output logic             o_ser_valid,
  output logic             o_ser_first,
  output logic             o_ser_last,
  output logic             o_busy
);

  localparam int unsigned CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_pbuf;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pvalid;
  logic             r_in_ready;
  logic             r_ser_out;
  logic             r_ser_valid;
  logic             r_ser_first;
  logic             r_ser_last;
  logic             r_busy;

  logic             w_accept;
  logic             w_last_bit;
  logic [CNT_W-1:0] w_cnt_inc;

  // Ready depends only on the pending flag, so there is no path from i_in_valid.
  assign w_accept   = i_in_valid && !r_pvalid;
  assign w_last_bit = (r_cnt == CNT_LAST);
  assign w_cnt_inc  = CNT_W'(r_cnt + CNT_W'(1));

  // FSM, datapath and registered outputs. Outputs are loaded with the values
  // that describe the bit being presented in the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sreg      <= '0;
      r_pbuf      <= '0;
      r_cnt       <= '0;
      r_pvalid    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_ser_first <= 1'b0;
      r_ser_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // Idle-looking outputs unless a branch below presents a bit.
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_ser_first <= 1'b0;
      r_ser_last  <= 1'b0;
      r_busy      <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_SHIFT;
            r_sreg      <= i_in_data;
            r_cnt       <= '0;
            r_ser_valid <= 1'b1;
            r_ser_out   <= i_in_data[WIDTH-1];
            r_ser_first <= 1'b1;
            r_busy      <= 1'b1;
          end
        end

        S_SHIFT: begin
          if (!w_last_bit) begin
            r_sreg      <= r_sreg << 1;
            r_cnt       <= w_cnt_inc;
            r_ser_valid <= 1'b1;
            r_ser_out   <= r_sreg[WIDTH-2];
            r_ser_last  <= (w_cnt_inc == CNT_LAST);
            r_busy      <= 1'b1;
            // Park the next word until the current one finishes.
            if (w_accept) begin
              r_pbuf     <= i_in_data;
              r_pvalid   <= 1'b1;
              r_in_ready <= 1'b0;
            end
          end else if (r_pvalid) begin
            // Pending word follows the LSB with no bubble.
            r_sreg      <= r_pbuf;
            r_pvalid    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_cnt       <= '0;
            r_ser_valid <= 1'b1;
            r_ser_out   <= r_pbuf[WIDTH-1];
            r_ser_first <= 1'b1;
            r_busy      <= 1'b1;
          end else if (w_accept) begin
            // Bypass: word arriving on the last-bit cycle goes straight in.
            r_sreg      <= i_in_data;
            r_cnt       <= '0;
            r_ser_valid <= 1'b1;
            r_ser_out   <= i_in_data[WIDTH-1];
            r_ser_first <= 1'b1;
            r_busy      <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_ser_out   = r_ser_out;
  assign o_ser_valid = r_ser_valid;
  assign o_ser_first = r_ser_first;
  assign o_ser_last  = r_ser_last;
  assign o_busy      = r_busy;

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the serial mod-5 divisibility detector (MSB-first, one bit per clock). It accepts WIDTH-bit words over a valid/ready handshake and shifts each word out MSB-first on `ser_out`. A one-word pending buffer lets consecutive words stream with no idle cycle between them. Frame markers `ser_first`/`ser_last` tell the downstream stage which cycle carries the final bit of each word, i.e. when its verdict is meaningful.

## Interface
- `WIDTH`, default 8: word width in bits; legal values are ≥ 2.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_data`  in  WIDTH: parallel word; sampled only on accept.
- `in_valid`  in  1: source presents a word.
- `in_ready`  out  1: block can take a word; accept = `in_valid && in_ready` at a posedge.
- `ser_out`  out  1: serial bit, MSB first; 0 when not valid.
- `ser_valid`  out  1: `ser_out` carries a word bit this cycle.
- `ser_first`  out  1: current bit is the MSB of a word.
- `ser_last`  out  1: current bit is the LSB of a word.
- `busy`  out  1: a word is shifting or pending.

## Operation
- State machine has two states, IDLE and SHIFT.
- Storage:
  - shift register `sreg[WIDTH]`
  - bit counter `cnt` of width `$clog2(WIDTH)`
  - pending buffer `pbuf[WIDTH]` with flag `pvalid`
- `in_ready = !pvalid`. It depends on registered state only; there is no combinational path from `in_valid`.
- IDLE, on accept: `sreg <= in_data`, `cnt <= 0`, go to SHIFT. Without accept, stay in IDLE. `pvalid` is always 0 in IDLE.
- SHIFT, when `cnt < WIDTH-1`:
  - `sreg <= sreg << 1`, `cnt <= cnt + 1`.
  - An accept writes `pbuf <= in_data` and sets `pvalid`.
- SHIFT, when `cnt == WIDTH-1` (last bit):
  - If `pvalid`: `sreg <= pbuf`, `pvalid <= 0`, `cnt <= 0`, stay in SHIFT.
  - Else, on accept this cycle: bypass, `sreg <= in_data`, `cnt <= 0`, stay in SHIFT.
  - Else: go to IDLE.
- Outputs:
  - In SHIFT: `ser_valid = 1`, `ser_out = sreg[WIDTH-1]`, `ser_first = (cnt == 0)`, `ser_last = (cnt == WIDTH-1)`.
  - In IDLE: `ser_valid`, `ser_out`, `ser_first` and `ser_last` are all 0.
  - `busy = (state == SHIFT) || pvalid`.
- `ser_out` is held at 0 while idle. Appending zeros preserves divisibility by 5, so idle gaps never change the downstream verdict.
- At most one word is pending. A source holding `in_valid` is stalled until the pending word moves into `sreg`.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE; `sreg`, `pbuf`, `cnt` = 0; `pvalid` = 0
  - `ser_out`, `ser_valid`, `ser_first`, `ser_last`, `busy` = 0
  - `in_ready` = 1
- Latency: a word accepted at edge k drives its MSB in the cycle after edge k. Its LSB appears WIDTH-1 cycles later.
- Throughput: one word per WIDTH cycles, with no bubble when the source keeps a word available.
- Pending slot timing:
  - The earliest pending accept is the edge ending the first bit of the current word.
  - `in_ready` returns to 1 in the cycle after the pending word is loaded into `sreg`.
- Accept on the last-bit cycle with `pvalid = 0` uses the bypass. The next word's MSB follows the LSB in the very next cycle.
- Reset mid-word aborts the current word, discards the pending word, and drops `ser_valid` immediately. There is no partial-frame completion.
- `in_data` changes without an accept have no effect.

## Test plan
- **Reset:** assert `rst_n = 0` mid-stream. Required: all outputs 0 except `in_ready = 1`. After release with `in_valid = 0`, outputs stay idle.
- **Single word, `WIDTH = 8`:** accept 0xA5 at edge 0.
  - Cycles 1–8: `ser_out` = 1,0,1,0,0,1,0,1 with `ser_valid = 1`.
  - `ser_first` only in cycle 1; `ser_last` only in cycle 8.
  - Cycle 9: `ser_valid = 0`, `ser_out = 0`, `busy = 0`.
- **Back-to-back:** hold `in_valid` with 0x0F, then 0xF0, then 0x3C.
  - Required: 24 contiguous valid bits, 00001111 11110000 00111100.
  - `in_ready` is low whenever a word is pending.
  - Exactly three accepts occur.
- **Bypass:** present 0x81 only on the last-bit cycle of a 0x7E word with nothing pending. Required: the 0x81 MSB follows the 0x7E LSB with no gap; `pvalid` never sets.
- **Reset mid-word:** accept 0xFF and a pending 0x55, then drop `rst_n` after 3 bits.
  - Required: outputs go to 0 at once; 0x55 is never emitted.
  - After release, the next accepted word starts with `ser_first`.
- **With the mod-5 detector downstream (both freshly reset):**
  - Stream 0x05: detector output is asserted in the `ser_last` cycle.
  - Stream 0x07: detector output is not asserted in the `ser_last` cycle.
  - Insert 4 idle cycles between the words: the verdicts are unchanged.
